tlk_link_pattern_checker: RTL and testbench

//  Parametrised multi-channel TLK link debug checker. Each channel compares every

---
 rtl/tlk_link_pattern_checker.sv | 178 +++++++++++++++++
 tb/tb_tlk_link_pattern_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk_link_pattern_checker.sv
// Multi-channel TLK receive-path pattern checker: per-channel SYNC/LOCKED tracking,
// saturating error counters, error pulses and sticky loss-of-lock flags.
module tlk_link_pattern_checker #(
  parameter int unsigned NCH      = 1,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [1:0]            cfg_mode,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic [NCH-1:0]        locked,
  output logic [NCH-1:0]        err_pulse,
  output logic [NCH*CNT_W-1:0]  err_cnt,
  output logic [NCH-1:0]        lol_sticky
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

  localparam logic [1:0] MODE_INC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  logic [1:0] mode_q;
  logic       force_idle_c;

  // Last mode seen; any change restarts every channel from IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_INC;
    end else begin
      mode_q <= cfg_mode;
    end
  end

  assign force_idle_c = !en || (cfg_mode == MODE_OFF) || (cfg_mode != mode_q);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pulse_q, pulse_d;
    logic                lol_q, lol_d;
    logic                locked_q, locked_d;
    logic [DATA_W-1:0]   word_c;
    logic [DATA_W-1:0]   expect_c;
    logic                good_word_c;

    assign word_c = in_data[c*DATA_W +: DATA_W];

    // Expected word from the previous one, wrapping at DATA_W bits
    always_comb begin
      expect_c = prev_q;
      unique case (cfg_mode)
        MODE_INC:  expect_c = DATA_W'(prev_q + DATA_W'(STEP));
        MODE_DEC:  expect_c = DATA_W'(prev_q - DATA_W'(STEP));
        MODE_HOLD: expect_c = prev_q;
        default:   expect_c = prev_q;
      endcase
    end

    assign good_word_c = (word_c == expect_c);

    // Next-state and counter logic
    always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      good_d   = good_q;
      bad_d    = bad_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      lol_d    = lol_q;

      if (force_idle_c) begin
        state_d = ST_IDLE;
        good_d  = '0;
        bad_d   = '0;
      end else if (in_valid[c]) begin
        prev_d = word_c;
        case (state_q)
          ST_IDLE: begin
            state_d = ST_SYNC;
            good_d  = '0;
          end
          ST_SYNC: begin
            if (good_word_c) begin
              if (GOOD_W'(good_q + GOOD_W'(1)) == GOOD_W'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                good_d  = '0;
                bad_d   = '0;
              end else begin
                good_d = GOOD_W'(good_q + GOOD_W'(1));
              end
            end else begin
              good_d = '0;
            end
          end
          ST_LOCKED: begin
            if (good_word_c) begin
              bad_d = '0;
            end else begin
              pulse_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
              end
              if (BAD_W'(bad_q + BAD_W'(1)) == BAD_W'(LOSS_CNT)) begin
                state_d = ST_SYNC;
                good_d  = '0;
                bad_d   = '0;
                lol_d   = 1'b1;
              end else begin
                bad_d = BAD_W'(bad_q + BAD_W'(1));
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            good_d  = '0;
            bad_d   = '0;
          end
        endcase
      end

      // Clear overrides any error or loss-of-lock in the same cycle
      if (clr) begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        lol_d   = 1'b0;
      end

      locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= ST_IDLE;
        prev_q   <= '0;
        good_q   <= '0;
        bad_q    <= '0;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        lol_q    <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        prev_q   <= prev_d;
        good_q   <= good_d;
        bad_q    <= bad_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
        lol_q    <= lol_d;
        locked_q <= locked_d;
      end
    end

    assign locked[c]                   = locked_q;
    assign err_pulse[c]                = pulse_q;
    assign lol_sticky[c]               = lol_q;
    assign err_cnt[c*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_tlk_link_pattern_checker.sv
// Directed bench for tlk_link_pattern_checker: a two-channel instance with default
// loss threshold and a single-channel instance with a large loss threshold.
module tb_tlk_link_pattern_checker;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [1:0]  cfg_mode;
  logic [1:0]  in_valid;
  logic [31:0] in_data;
  logic [1:0]  locked;
  logic [1:0]  err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  lol_sticky;

  logic        in_valid_s;
  logic [15:0] in_data_s;
  logic        locked_s;
  logic        err_pulse_s;
  logic [7:0]  err_cnt_s;
  logic        lol_sticky_s;

  int checks;
  int errors;

  tlk_link_pattern_checker #(
    .NCH(2), .DATA_W(16), .CNT_W(8), .STEP(1), .LOCK_CNT(4), .LOSS_CNT(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_data(in_data), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .lol_sticky(lol_sticky)
  );

  tlk_link_pattern_checker #(
    .NCH(1), .DATA_W(16), .CNT_W(8), .STEP(1), .LOCK_CNT(4), .LOSS_CNT(1024)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_mode(cfg_mode),
    .in_valid(in_valid_s), .in_data(in_data_s), .locked(locked_s),
    .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .lol_sticky(lol_sticky_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs already driven, outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [15:0] d);
    in_valid = 2'b01;
    in_data  = {16'h0000, d};
    tick();
    in_valid = 2'b00;
  endtask

  task automatic idle_cycle();
    in_valid   = 2'b00;
    in_valid_s = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({locked, err_pulse, err_cnt, lol_sticky} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {locked, err_pulse, err_cnt, lol_sticky});
    end
    checks++;
    if ({locked_s, err_pulse_s, err_cnt_s, lol_sticky_s} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs_sat: got %h expected 0", {locked_s, err_pulse_s, err_cnt_s, lol_sticky_s});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b1;
    idle_cycle();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 10; i++) begin
      send0(16'(i));
      checks++;
      if (locked !== {1'b0, (i >= 4)}) begin
        errors++;
        $display("FAIL lock_word%0d: locked=%b expected %b", i, locked, {1'b0, (i >= 4)});
      end
    end
    checks++;
    if (err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL lock_err_cnt: got %h expected 0000", err_cnt);
    end
  endtask

  task automatic test_single_error();
    send0(16'h000A);
    send0(16'h0010);
    checks++;
    if (err_pulse !== 2'b01 || err_cnt !== 16'h0001 || locked !== 2'b01) begin
      errors++;
      $display("FAIL single_err: pulse=%b cnt=%h locked=%b expected 01 0001 01", err_pulse, err_cnt, locked);
    end
    send0(16'h0011);
    checks++;
    if (err_pulse !== 2'b00 || err_cnt !== 16'h0001 || locked !== 2'b01) begin
      errors++;
      $display("FAIL single_err_recover: pulse=%b cnt=%h locked=%b expected 00 0001 01", err_pulse, err_cnt, locked);
    end
  endtask

  task automatic test_loss_of_lock();
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    checks++;
    if (err_cnt !== 16'h0000 || lol_sticky !== 2'b00) begin
      errors++;
      $display("FAIL clr_before_loss: cnt=%h lol=%b expected 0000 00", err_cnt, lol_sticky);
    end
    for (int i = 1; i <= 8; i++) begin
      send0(16'h0011);
      if (i == 7) begin
        checks++;
        if (locked !== 2'b01 || err_cnt !== 16'h0007 || lol_sticky !== 2'b00) begin
          errors++;
          $display("FAIL loss_bad7: locked=%b cnt=%h lol=%b expected 01 0007 00", locked, err_cnt, lol_sticky);
        end
      end
    end
    checks++;
    if (locked !== 2'b00 || err_cnt !== 16'h0008 || lol_sticky !== 2'b01) begin
      errors++;
      $display("FAIL loss_bad8: locked=%b cnt=%h lol=%b expected 00 0008 01", locked, err_cnt, lol_sticky);
    end
    for (int i = 0; i < 4; i++) begin
      send0(16'(16'h0012 + i));
      checks++;
      if (locked !== {1'b0, (i == 3)} || lol_sticky !== 2'b01) begin
        errors++;
        $display("FAIL relock_word%0d: locked=%b lol=%b expected %b 01", i, locked, lol_sticky, {1'b0, (i == 3)});
      end
    end
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    checks++;
    if (lol_sticky !== 2'b00 || err_cnt !== 16'h0000 || locked !== 2'b01) begin
      errors++;
      $display("FAIL clr_after_relock: lol=%b cnt=%h locked=%b expected 00 0000 01", lol_sticky, err_cnt, locked);
    end
  endtask

  task automatic test_saturation();
    in_valid_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_s = 16'(i);
      tick();
    end
    checks++;
    if (locked_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_lock: locked=%b expected 1", locked_s);
    end
    in_data_s = 16'h0004;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254) begin
        checks++;
        if (err_cnt_s !== 8'hFE) begin
          errors++;
          $display("FAIL sat_254: cnt=%h expected fe", err_cnt_s);
        end
      end
    end
    checks++;
    if (err_cnt_s !== 8'hFF || err_pulse_s !== 1'b1 || locked_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_300: cnt=%h pulse=%b locked=%b expected ff 1 1", err_cnt_s, err_pulse_s, locked_s);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid_s = 1'b0;
    checks++;
    if (err_cnt_s !== 8'h00 || err_pulse_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr_wins: cnt=%h pulse=%b expected 00 0", err_cnt_s, err_pulse_s);
    end
  endtask

  task automatic test_wrap_modes();
    logic [15:0] inc_seq [5];
    logic [15:0] dec_seq [5];
    inc_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    dec_seq = '{16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
    en = 1'b0;
    idle_cycle();
    en = 1'b1;
    checks++;
    if (locked !== 2'b00) begin
      errors++;
      $display("FAIL en_low_unlock: locked=%b expected 00", locked);
    end
    for (int i = 0; i < 5; i++) begin
      send0(inc_seq[i]);
      checks++;
      if (err_pulse !== 2'b00) begin
        errors++;
        $display("FAIL inc_wrap_pulse%0d: pulse=%b expected 00", i, err_pulse);
      end
    end
    checks++;
    if (locked !== 2'b01 || err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap_lock: locked=%b cnt=%h expected 01 0000", locked, err_cnt);
    end
    cfg_mode = 2'b01;
    idle_cycle();
    for (int i = 0; i < 5; i++) send0(dec_seq[i]);
    checks++;
    if (locked !== 2'b01 || err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL dec_wrap_lock: locked=%b cnt=%h expected 01 0000", locked, err_cnt);
    end
    cfg_mode = 2'b11;
    for (int i = 0; i < 6; i++) send0(16'(i));
    checks++;
    if (locked !== 2'b00) begin
      errors++;
      $display("FAIL off_mode: locked=%b expected 00", locked);
    end
    cfg_mode = 2'b10;
    idle_cycle();
    for (int i = 0; i < 5; i++) send0(16'hA5A5);
    checks++;
    if (locked !== 2'b01 || err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL hold_lock: locked=%b cnt=%h expected 01 0000", locked, err_cnt);
    end
    send0(16'hA5A6);
    checks++;
    if (err_pulse !== 2'b01 || err_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL hold_err: pulse=%b cnt=%h expected 01 0001", err_pulse, err_cnt);
    end
  endtask

  task automatic test_mode_change_and_reset();
    cfg_mode = 2'b00;
    idle_cycle();
    checks++;
    if (locked !== 2'b00 || err_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL mode_change: locked=%b cnt=%h expected 00 0001", locked, err_cnt);
    end
    for (int i = 0; i < 5; i++) send0(16'(16'h0100 + i));
    checks++;
    if (locked !== 2'b01) begin
      errors++;
      $display("FAIL relock_inc: locked=%b expected 01", locked);
    end
    in_valid = 2'b01;
    in_data  = 32'h0000_0105;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, err_cnt, lol_sticky} !== 22'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {locked, err_pulse, err_cnt, lol_sticky});
    end
    in_valid = 2'b00;
    #10 rst = 1'b1;
    idle_cycle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    en         = 1'b0;
    clr        = 1'b0;
    cfg_mode   = 2'b00;
    in_valid   = 2'b00;
    in_data    = '0;
    in_valid_s = 1'b0;
    in_data_s  = '0;

    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_saturation();
    test_wrap_modes();
    test_mode_change_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
